// File: rtl/sram_array_init.sv
// sram_array_init: single-port entry array that sweeps INIT_VALUE into every
// entry after reset or flush, then serves masked writes and registered reads.
module sram_array_init #(
  parameter int                  CACHE_ADDR_WIDTH = 9,
  parameter int                  SET_SIZE         = 111,
  parameter logic [SET_SIZE-1:0] INIT_VALUE       = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CACHE_ADDR_WIDTH-1:0] addr,
  input  logic [SET_SIZE-1:0]         wd,
  input  logic [SET_SIZE-1:0]         wmask,
  input  logic                        we,
  input  logic                        re,
  input  logic                        flush,
  output logic [SET_SIZE-1:0]         rd,
  output logic                        rvalid,
  output logic                        ready
);

  localparam int                          DEPTH    = 2**CACHE_ADDR_WIDTH;
  localparam logic [CACHE_ADDR_WIDTH-1:0] LAST_PTR = {CACHE_ADDR_WIDTH{1'b1}};
  localparam logic [CACHE_ADDR_WIDTH-1:0] PTR_ONE  = {{(CACHE_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {INIT, READY} state_t;

  state_t                        state_q, state_d;
  logic [CACHE_ADDR_WIDTH-1:0]   init_ptr;
  logic [SET_SIZE-1:0]           mem [DEPTH];
  logic [SET_SIZE-1:0]           merged;
  logic                          wr_en;
  logic [CACHE_ADDR_WIDTH-1:0]   wr_addr;
  logic [SET_SIZE-1:0]           wr_data;
  logic                          rd_fire;
  logic                          wr_fire;

  assign ready   = (state_q == READY);
  assign rd_fire = ready & re;
  assign wr_fire = ready & we;
  // Read-modify-write merge; also the write-first bypass value for rd.
  assign merged  = (mem[addr] & ~wmask) | (wd & wmask);

  // FSM state register; sweep always restarts from entry 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next state and the single shared write port: sweep owns it in INIT,
  // user writes own it in READY, so only one array write per cycle.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = merged;
    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = init_ptr;
        wr_data = INIT_VALUE;
        if (init_ptr == LAST_PTR) state_d = READY;
      end
      READY: begin
        wr_en = wr_fire;
        if (flush) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  // Sweep pointer; advances only while sweeping and wraps to 0 on the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_ptr <= '0;
    else if (state_q == INIT)  init_ptr <= init_ptr + PTR_ONE;
  end

  // Array storage, no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read with write-first bypass; rd holds when no read fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd     <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) rd <= we ? merged : mem[addr];
    end
  end

endmodule
